// File: rtl/spi_flash_writer_if.sv
// rtl/spi_flash_writer_if.sv - request/completion bus between CPU-side logic and spi_flash_writer
interface spi_flash_writer_if;
    logic        start;
    logic        op;
    logic [23:0] addr;
    logic [31:0] wdata;
    logic        busy;
    logic        done;
    logic        error;
    logic [7:0]  status;

    modport master (
        output start, op, addr, wdata,
        input  busy, done, error, status
    );

    modport slave (
        input  start, op, addr, wdata,
        output busy, done, error, status
    );
endinterface

// File: rtl/spi_flash_writer.sv
// rtl/spi_flash_writer.sv - SPI NOR program/erase sequencer: WREN, PP/SE, RDSR polling
module spi_flash_writer #(
    parameter int CLK_DIV        = 1,
    parameter int CS_HIGH_CYCLES = 4,
    parameter int POLL_MAX       = 65535
) (
    input  logic               clk,
    input  logic               resetn,
    spi_flash_writer_if.slave  req,
    output logic               flashClk,
    output logic               flashCs,
    output logic               flashMosi,
    input  logic               flashMiso
);

    localparam int DW = $clog2(CLK_DIV + 1);
    localparam int GW = $clog2(CS_HIGH_CYCLES + 1);
    localparam int PW = $clog2(POLL_MAX + 1);
    localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
    localparam logic [GW-1:0] GAP_LAST = GW'(CS_HIGH_CYCLES - 1);
    localparam logic [PW-1:0] POLL_LIM = PW'(POLL_MAX);

    typedef enum logic [2:0] {
        S_IDLE, S_WREN, S_GAP1, S_CMD, S_GAP2, S_POLL, S_PGAP, S_DONE
    } state_t;

    state_t          state, state_next;
    logic            op_q;
    logic [23:0]     addr_q;
    logic [31:0]     wdata_q;
    logic [63:0]     shreg;
    logic [6:0]      bit_cnt;
    logic [DW-1:0]   div_cnt;
    logic            sck_ph;
    logic [GW-1:0]   gap_cnt;
    logic [PW-1:0]   poll_cnt;
    logic [7:0]      status_q;
    logic            error_q;

    logic ld_wren, ld_cmd, ld_poll, accept, set_err, poll_inc;

    wire shifting  = (state == S_WREN) || (state == S_CMD) || (state == S_POLL);
    wire in_gap    = (state == S_GAP1) || (state == S_GAP2) || (state == S_PGAP);
    wire div_last  = (div_cnt == DIV_LAST);
    wire last_bit  = shifting && sck_ph && div_last && (bit_cnt == 7'd1);
    wire gap_last  = (gap_cnt == GAP_LAST);
    wire unaligned = !req.op && (req.addr[1:0] != 2'b00);
    wire poll_over = ((poll_cnt + PW'(1)) == POLL_LIM);

    // Pins decode straight from registered state so a reset releases CS immediately.
    assign flashCs    = !shifting;
    assign flashClk   = shifting && sck_ph;
    assign flashMosi  = shifting && shreg[63];
    assign req.busy   = (state != S_IDLE) && (state != S_DONE);
    assign req.done   = (state == S_DONE);
    assign req.error  = error_q;
    assign req.status = status_q;

    // State register.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) state <= S_IDLE;
        else         state <= state_next;
    end

    // Next-state decode and the load/flag strobes for the datapath.
    always_comb begin
        state_next = state;
        ld_wren    = 1'b0;
        ld_cmd     = 1'b0;
        ld_poll    = 1'b0;
        accept     = 1'b0;
        set_err    = 1'b0;
        poll_inc   = 1'b0;
        case (state)
            S_IDLE: begin
                if (req.start) begin
                    accept = 1'b1;
                    if (unaligned) begin
                        set_err    = 1'b1;
                        state_next = S_DONE;
                    end else begin
                        ld_wren    = 1'b1;
                        state_next = S_WREN;
                    end
                end
            end
            S_WREN: if (last_bit) state_next = S_GAP1;
            S_GAP1: begin
                if (gap_last) begin
                    ld_cmd     = 1'b1;
                    state_next = S_CMD;
                end
            end
            S_CMD:  if (last_bit) state_next = S_GAP2;
            S_GAP2, S_PGAP: begin
                if (gap_last) begin
                    ld_poll    = 1'b1;
                    state_next = S_POLL;
                end
            end
            S_POLL: begin
                if (last_bit) begin
                    if (!status_q[0]) begin
                        state_next = S_DONE;
                    end else if (poll_over) begin
                        set_err    = 1'b1;
                        state_next = S_DONE;
                    end else begin
                        poll_inc   = 1'b1;
                        state_next = S_PGAP;
                    end
                end
            end
            S_DONE:  state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    // Request capture, bit shifter, SCK phase timing, gap and poll counters, status/error.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            op_q     <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            shreg    <= '0;
            bit_cnt  <= '0;
            div_cnt  <= '0;
            sck_ph   <= 1'b0;
            gap_cnt  <= '0;
            poll_cnt <= '0;
            status_q <= 8'h00;
            error_q  <= 1'b0;
        end else begin
            gap_cnt <= in_gap ? gap_cnt + GW'(1) : '0;

            if (accept) begin
                op_q     <= req.op;
                addr_q   <= req.addr;
                wdata_q  <= req.wdata;
                poll_cnt <= '0;
                error_q  <= set_err;
            end else if (set_err) begin
                error_q  <= 1'b1;
            end

            if (poll_inc) poll_cnt <= poll_cnt + PW'(1);

            if (ld_wren || ld_cmd || ld_poll) begin
                div_cnt <= '0;
                sck_ph  <= 1'b0;
                if (ld_wren) begin
                    shreg   <= {8'h06, 56'h0};
                    bit_cnt <= 7'd8;
                end else if (ld_poll) begin
                    shreg   <= {8'h05, 56'h0};
                    bit_cnt <= 7'd16;
                end else if (!op_q) begin
                    // Program data goes out little-endian by byte, each byte MSB first.
                    shreg   <= {8'h02, addr_q, wdata_q[7:0], wdata_q[15:8],
                                wdata_q[23:16], wdata_q[31:24]};
                    bit_cnt <= 7'd64;
                end else begin
                    shreg   <= {8'h20, addr_q, 32'h0};
                    bit_cnt <= 7'd32;
                end
            end else if (shifting) begin
                if (div_last) begin
                    div_cnt <= '0;
                    sck_ph  <= !sck_ph;
                    if (!sck_ph) begin
                        // Rising SCK: the last 8 bits of an RDSR are the status byte.
                        if ((state == S_POLL) && (bit_cnt <= 7'd8))
                            status_q <= {status_q[6:0], flashMiso};
                    end else begin
                        shreg   <= {shreg[62:0], 1'b0};
                        bit_cnt <= bit_cnt - 7'd1;
                    end
                end else begin
                    div_cnt <= div_cnt + DW'(1);
                end
            end
        end
    end

endmodule
